// File: rtl/wt_mem_if.sv
// Request/response port between the write-through cache path and its memory-side responder.
// Signal suffixes are from the responder's point of view.
interface wt_mem_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TID_WIDTH  = 2
);
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_we_i;
  logic [TID_WIDTH-1:0]    req_tid_i;
  logic [ADDR_WIDTH-1:0]   req_addr_i;
  logic [DATA_WIDTH-1:0]   req_wdata_i;
  logic [DATA_WIDTH/8-1:0] req_be_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [TID_WIDTH-1:0]    rsp_tid_o;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;
  logic                    rsp_err_o;
  logic [TID_WIDTH:0]      outstanding_o;

  modport slave (
    input  req_valid_i, req_we_i, req_tid_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_tid_o, rsp_rdata_o, rsp_err_o, outstanding_o
  );

  modport master (
    output req_valid_i, req_we_i, req_tid_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_tid_o, rsp_rdata_o, rsp_err_o, outstanding_o
  );
endinterface

// File: rtl/wt_mem_responder.sv
// Memory-side responder: word-organised backing store with an in-order,
// fixed-minimum-latency tagged response queue.
module wt_mem_responder #(
  parameter int unsigned            ADDR_WIDTH = 64,
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            TID_WIDTH  = 2,
  parameter int unsigned            MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(64'h8000_0000),
  parameter int unsigned            LATENCY    = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  wt_mem_if.slave   bus
);

  localparam int unsigned BE_W     = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(BE_W);
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam int unsigned DEPTH    = 2 ** TID_WIDTH;
  localparam int unsigned CNT_W    = 4;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * BE_W);

  typedef struct packed {
    logic                  valid;
    logic [TID_WIDTH-1:0]  tid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic [CNT_W-1:0]      cnt;
  } entry_t;

  entry_t                 ent_q [DEPTH];
  entry_t                 ent_d [DEPTH];
  logic [TID_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [TID_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TID_WIDTH:0]     count_q, count_d;

  logic [DATA_WIDTH-1:0]  mem_q [MEM_WORDS];

  logic [ADDR_WIDTH-1:0]  offset;
  logic [IDX_W-1:0]       idx;
  logic                   in_range;
  logic                   dup;
  logic                   req_err;
  logic                   push;
  logic                   pop;
  logic                   rsp_valid;
  entry_t                 head;

  // Address decode and error classification of the incoming request.
  always_comb begin
    offset   = bus.req_addr_i - BASE_ADDR;
    in_range = (offset < MEM_BYTES);
    idx      = offset[OFF_BITS +: IDX_W];
    dup      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && (ent_q[i].tid == bus.req_tid_i)) dup = 1'b1;
    end
    req_err  = !in_range || dup;
  end

  assign head      = ent_q[rd_ptr_q];
  assign rsp_valid = head.valid && (head.cnt == '0);
  assign push      = bus.req_valid_i && bus.req_ready_o;
  assign pop       = rsp_valid && bus.rsp_ready_i;

  assign bus.req_ready_o   = (count_q < (TID_WIDTH+1)'(DEPTH));
  assign bus.rsp_valid_o   = rsp_valid;
  assign bus.rsp_tid_o     = rsp_valid ? head.tid   : '0;
  assign bus.rsp_rdata_o   = rsp_valid ? head.rdata : '0;
  assign bus.rsp_err_o     = rsp_valid ? head.err   : 1'b0;
  assign bus.outstanding_o = count_q;

  // Queue next state: age all entries, then retire the head and append the new request.
  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && (ent_q[i].cnt != '0)) ent_d[i].cnt = ent_q[i].cnt - 1'b1;
    end
    if (pop) begin
      ent_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d              = rd_ptr_q + 1'b1;
    end
    if (push) begin
      ent_d[wr_ptr_q].valid = 1'b1;
      ent_d[wr_ptr_q].tid   = bus.req_tid_i;
      ent_d[wr_ptr_q].err   = req_err;
      ent_d[wr_ptr_q].rdata = (!req_err && !bus.req_we_i) ? mem_q[idx] : '0;
      ent_d[wr_ptr_q].cnt   = CNT_W'(LATENCY - 1);
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Backing store is deliberately not reset so accepted writes survive a queue reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push && bus.req_we_i && !req_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.req_be_i[b]) mem_q[idx][b*8 +: 8] <= bus.req_wdata_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wt_mem_responder.sv
// Directed plus randomized bench for wt_mem_responder against a transaction-level queue model.
module tb_wt_mem_responder;

  localparam int unsigned LAT  = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'd8192;

  typedef struct {
    logic [1:0]  tid;
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wt_mem_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TID_WIDTH(2)) bus ();

  wt_mem_responder #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .TID_WIDTH(2), .MEM_WORDS(1024),
    .BASE_ADDR(64'h8000_0000), .LATENCY(LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        q[$];
  logic [7:0]  mem_b [longint unsigned];
  logic [63:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic head_due();
    return (q.size() > 0) && (q[0].acc + int'(LAT) - 1 <= cyc);
  endfunction

  // One clock: sample stimulus, advance the model across the edge, then compare outputs.
  task automatic cycle();
    logic        v, we, rr, acc, pop, dup, inr;
    logic [1:0]  tid;
    logic [63:0] a, wd, off, dout;
    logic [7:0]  be;
    exp_t        e;
    v = bus.req_valid_i; we = bus.req_we_i; tid = bus.req_tid_i; a = bus.req_addr_i;
    wd = bus.req_wdata_i; be = bus.req_be_i; rr = bus.rsp_ready_i; dout = bus.rsp_rdata_o;
    acc = v && (q.size() < 4);
    pop = head_due() && rr;
    dup = 1'b0;
    foreach (q[i]) if (q[i].tid == tid) dup = 1'b1;
    off = a - BASE;
    inr = off < SIZE;
    @(posedge clk);
    cyc++;
    if (pop) begin
      last_rdata = dout;
      void'(q.pop_front());
    end
    if (acc) begin
      e.tid = tid; e.err = !inr || dup; e.rdata = 64'h0; e.acc = cyc;
      if (!e.err) begin
        for (int i = 0; i < 8; i++) begin
          if (we && be[i]) mem_b[(off & ~64'h7) + 64'(i)] = wd[i*8 +: 8];
          if (!we) e.rdata[i*8 +: 8] = mem_b[(off & ~64'h7) + 64'(i)];
        end
      end
      q.push_back(e);
    end
    #1;
    chk("req_ready", 64'(bus.req_ready_o), 64'(q.size() < 4));
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(head_due()));
    chk("outstanding", 64'(bus.outstanding_o), 64'(q.size()));
    if (head_due()) begin
      chk("rsp_tid", 64'(bus.rsp_tid_o), 64'(q[0].tid));
      chk("rsp_rdata", bus.rsp_rdata_o, q[0].rdata);
      chk("rsp_err", 64'(bus.rsp_err_o), 64'(q[0].err));
    end
  endtask

  task automatic req(input logic we, input logic [1:0] tid, input logic [63:0] a,
                     input logic [63:0] wd, input logic [7:0] be);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_tid_i = tid;
    bus.req_addr_i = a; bus.req_wdata_i = wd; bus.req_be_i = be;
    cycle();
  endtask

  task automatic idle(input int n);
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
    chk("drain_timeout", 64'(q.size()), 64'h0);
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_tid_i = '0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0; bus.req_be_i = '0; bus.rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'h1);
    chk("rst_valid", 64'(bus.rsp_valid_o), 64'h0);
    chk("rst_tid", 64'(bus.rsp_tid_o), 64'h0);
    chk("rst_rdata", bus.rsp_rdata_o, 64'h0);
    chk("rst_err", 64'(bus.rsp_err_o), 64'h0);
    chk("rst_outstanding", 64'(bus.outstanding_o), 64'h0);
    rst = 1'b0;
    idle(1);

    // Full write then read back.
    req(1'b1, 2'd1, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    req(1'b0, 2'd2, 64'h8000_0010, 64'h0, 8'h00);
    drain();
    chk("wr_rd_data", last_rdata, 64'hDEAD_BEEF_0123_4567);

    // Partial write over zero.
    req(1'b1, 2'd0, 64'h8000_0020, 64'h0, 8'hFF);
    req(1'b1, 2'd1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    req(1'b0, 2'd2, 64'h8000_0020, 64'h0, 8'h00);
    drain();
    chk("partial_data", last_rdata, 64'h0000_0000_FFFF_FFFF);

    // Out-of-range accesses on both sides of the window.
    req(1'b0, 2'd0, 64'h7FFF_FFF8, 64'h0, 8'h00);
    req(1'b1, 2'd1, 64'h8000_2000, 64'h1234, 8'hFF);
    req(1'b0, 2'd2, 64'h8000_2000, 64'h0, 8'h00);
    drain();

    // Fill the queue with the consumer stalled, then release.
    bus.rsp_ready_i = 1'b0;
    for (int t = 0; t < 4; t++) req(1'b0, 2'(t), 64'h8000_0010, 64'h0, 8'h00);
    chk("full_ready", 64'(bus.req_ready_o), 64'h0);
    chk("full_outstanding", 64'(bus.outstanding_o), 64'h4);
    req(1'b0, 2'd0, 64'h8000_0010, 64'h0, 8'h00);
    cycle();
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    drain();

    // Duplicate outstanding TID: second write must be rejected.
    bus.rsp_ready_i = 1'b0;
    req(1'b1, 2'd3, 64'h8000_0040, 64'h1111_1111_1111_1111, 8'hFF);
    req(1'b1, 2'd3, 64'h8000_0040, 64'h2222_2222_2222_2222, 8'hFF);
    drain();
    req(1'b0, 2'd0, 64'h8000_0040, 64'h0, 8'h00);
    drain();
    chk("dup_keep", last_rdata, 64'h1111_1111_1111_1111);

    // Reset with pending entries; memory must survive.
    req(1'b1, 2'd0, 64'h8000_0080, 64'hCAFE_F00D_5555_AAAA, 8'hFF);
    drain();
    bus.rsp_ready_i = 1'b0;
    for (int t = 1; t < 4; t++) req(1'b0, 2'(t), 64'h8000_0080, 64'h0, 8'h00);
    idle(1);
    chk("pre_rst_outstanding", 64'(bus.outstanding_o), 64'h3);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.rsp_valid_o), 64'h0);
    chk("midrst_outstanding", 64'(bus.outstanding_o), 64'h0);
    chk("midrst_ready", 64'(bus.req_ready_o), 64'h1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req(1'b0, 2'd1, 64'h8000_0080, 64'h0, 8'h00);
    drain();
    chk("post_rst_data", last_rdata, 64'hCAFE_F00D_5555_AAAA);

    // Pre-write a window so random reads never see unwritten words.
    for (int i = 0; i < 16; i++)
      req(1'b1, 2'(i % 4), BASE + 64'(i * 8), {$urandom, $urandom}, 8'hFF);
    drain();

    // Random traffic with random back-pressure.
    for (int n = 0; n < 400; n++) begin
      logic [63:0] a;
      if ($urandom_range(9) == 0) a = ($urandom_range(1) == 0) ? BASE - 64'd8 : BASE + SIZE + 64'(8 * $urandom_range(15));
      else a = BASE + 64'(8 * $urandom_range(15)) + 64'($urandom_range(7));
      bus.req_valid_i = ($urandom_range(3) != 0);
      bus.req_we_i    = $urandom_range(1) == 1;
      bus.req_tid_i   = 2'($urandom_range(3));
      bus.req_addr_i  = a;
      bus.req_wdata_i = {$urandom, $urandom};
      bus.req_be_i    = 8'($urandom);
      bus.rsp_ready_i = ($urandom_range(3) != 0);
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
